fetch_stage: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined successor of the single-cycle CPU.
- Owns the PC register, next-PC selection, the IF/ID pipeline register, syscall halt/go control and the performance counters.
- Sits between the instruction ROM, which is combinational-read, and the ID stage.
- Takes redirect, stall and halt requests from the later stages.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/counter.sv | 18 +
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU front end.
package cpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/counter.sv
// Free-running enabled up-counter that wraps to zero after all-ones.
module counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, next-PC select, IF/ID register,
// syscall halt/go control and performance counters.
//
// state | meaning
// RUN   | fetching; honours halt_req, redirect and stall
// HALT  | halted by syscall; PC and IF/ID frozen until go
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                ROM_AW   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              stall,
    input  logic              redirect,
    input  logic              redirect_cond,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic [31:0]       rom_data_out,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  total_cycles,
    output logic [CNT_W-1:0]  condi_branch_num,
    output logic [CNT_W-1:0]  uncondi_branch_num,
    output logic [CNT_W-1:0]  stall_cycles
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_pc;
    logic [31:0]       instr_nx;
    logic [ADDR_W-1:0] pc4_nx;
    logic              valid_nx;
    logic              run;

    assign pc_plus4  = pc + ADDR_W'(4);
    // Low two bits of the target are dropped by masking so every bit is used.
    assign target_pc = redirect_pc & ~ADDR_W'(3);
    assign rom_addr  = pc[ROM_AW+1:2];
    assign run       = (state == RUN);
    assign halted    = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            ifid_instr <= instr_nx;
            ifid_pc4   <= pc4_nx;
            ifid_valid <= valid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = ifid_instr;
        pc4_nx   = ifid_pc4;
        valid_nx = ifid_valid;
        case (state)
            RUN: begin
                if (halt_req) begin
                    pc_nx    = target_pc;
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                    state_nx = HALT;
                end else if (redirect) begin
                    pc_nx    = target_pc;
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                end else if (!stall) begin
                    pc_nx    = pc_plus4;
                    instr_nx = rom_data_out;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                end
            end
            HALT: begin
                valid_nx = 1'b0;
                if (go)
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    counter #(.W(CNT_W)) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .count (total_cycles)
    );

    counter #(.W(CNT_W)) u_condi_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run && redirect && redirect_cond && !halt_req),
        .count (condi_branch_num)
    );

    counter #(.W(CNT_W)) u_uncondi_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run && redirect && !redirect_cond && !halt_req),
        .count (uncondi_branch_num)
    );

    counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run && stall && !redirect && !halt_req),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-width instance for the main
// sequence and a narrow instance (12-bit PC, 4-bit counters) for wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        go, stall, redirect, redirect_cond, halt_req;
    logic [31:0] redirect_pc;
    logic [31:0] rom [0:1023];

    logic [9:0]  rom_addr;
    logic [31:0] rom_data_out, ifid_instr, ifid_pc4;
    logic        ifid_valid, halted;
    logic [31:0] total_cycles, condi_branch_num, uncondi_branch_num, stall_cycles;

    logic [9:0]  rom_addr2;
    logic [31:0] rom_data_out2, ifid_instr2;
    logic [11:0] ifid_pc4_2;
    logic        ifid_valid2, halted2;
    logic [3:0]  total2, condi2, uncondi2, stall2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data_out  = rom[rom_addr];
    assign rom_data_out2 = rom[rom_addr2];

    fetch_stage dut (
        .clk                (clk),
        .rst                (rst),
        .go                 (go),
        .stall              (stall),
        .redirect           (redirect),
        .redirect_cond      (redirect_cond),
        .redirect_pc        (redirect_pc),
        .halt_req           (halt_req),
        .rom_data_out       (rom_data_out),
        .rom_addr           (rom_addr),
        .ifid_instr         (ifid_instr),
        .ifid_pc4           (ifid_pc4),
        .ifid_valid         (ifid_valid),
        .halted             (halted),
        .total_cycles       (total_cycles),
        .condi_branch_num   (condi_branch_num),
        .uncondi_branch_num (uncondi_branch_num),
        .stall_cycles       (stall_cycles)
    );

    fetch_stage #(.ADDR_W(12), .ROM_AW(10), .RESET_PC(12'hFFC), .CNT_W(4)) dut2 (
        .clk                (clk),
        .rst                (rst2),
        .go                 (1'b0),
        .stall              (1'b0),
        .redirect           (1'b0),
        .redirect_cond      (1'b0),
        .redirect_pc        (12'h0),
        .halt_req           (1'b0),
        .rom_data_out       (rom_data_out2),
        .rom_addr           (rom_addr2),
        .ifid_instr         (ifid_instr2),
        .ifid_pc4           (ifid_pc4_2),
        .ifid_valid         (ifid_valid2),
        .halted             (halted2),
        .total_cycles       (total2),
        .condi_branch_num   (condi2),
        .uncondi_branch_num (uncondi2),
        .stall_cycles       (stall2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag, input int tc, input int cb, input int ub, input int sc);
        check({tag, ".total"},   64'(total_cycles),       64'(tc));
        check({tag, ".condi"},   64'(condi_branch_num),   64'(cb));
        check({tag, ".uncondi"}, 64'(uncondi_branch_num), 64'(ub));
        check({tag, ".stall"},   64'(stall_cycles),       64'(sc));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            rom[i] = 32'hA000_0000 | 32'(i);

        rst = 1'b1; rst2 = 1'b1;
        go = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_cond = 1'b0;
        halt_req = 1'b0; redirect_pc = 32'h0;
        #12 rst = 1'b0;

        check("rst.rom_addr", 64'(rom_addr), 64'h0);
        check("rst.valid",    64'(ifid_valid), 64'h0);
        check("rst.instr",    64'(ifid_instr), 64'h0);
        check("rst.pc4",      64'(ifid_pc4),   64'h0);
        check("rst.halted",   64'(halted),     64'h0);
        check_counters("rst", 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seq%0d.instr", i), 64'(ifid_instr), 64'(32'hA000_0000 + i));
            check($sformatf("seq%0d.pc4", i),   64'(ifid_pc4),   64'(4 * (i + 1)));
            check($sformatf("seq%0d.valid", i), 64'(ifid_valid), 64'h1);
        end
        check("seq.total", 64'(total_cycles), 64'd4);

        // run on to pc = 0x40, then reset asynchronously between edges
        repeat (12) step();
        check("pre_rst.rom_addr", 64'(rom_addr), 64'h10);
        #1 rst = 1'b1;
        #1;
        check("arst.rom_addr", 64'(rom_addr),   64'h0);
        check("arst.valid",    64'(ifid_valid), 64'h0);
        check("arst.instr",    64'(ifid_instr), 64'h0);
        check_counters("arst", 0, 0, 0, 0);
        #1 rst = 1'b0;

        step(); step();
        check("pc8.rom_addr", 64'(rom_addr), 64'h2);
        stall = 1'b1;
        step(); step();
        check("stall.rom_addr", 64'(rom_addr),   64'h2);
        check("stall.instr",    64'(ifid_instr), 64'hA000_0001);
        check("stall.pc4",      64'(ifid_pc4),   64'h8);
        check("stall.valid",    64'(ifid_valid), 64'h1);
        check_counters("stall", 4, 0, 0, 2);

        redirect = 1'b1; redirect_cond = 1'b1; redirect_pc = 32'h23;
        step();
        check("cbr.rom_addr", 64'(rom_addr),   64'h8);
        check("cbr.valid",    64'(ifid_valid), 64'h0);
        check("cbr.instr",    64'(ifid_instr), 64'h0);
        check_counters("cbr", 5, 1, 0, 2);

        stall = 1'b0; redirect_cond = 1'b0; redirect_pc = 32'h100;
        step();
        check("ubr.rom_addr", 64'(rom_addr), 64'h40);
        check_counters("ubr", 6, 1, 1, 2);
        redirect = 1'b0;
        step();
        check("ubr.instr", 64'(ifid_instr), 64'hA000_0040);
        check("ubr.pc4",   64'(ifid_pc4),   64'h104);
        check("ubr.valid", 64'(ifid_valid), 64'h1);

        halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h54;
        step();
        check("halt.halted",   64'(halted),     64'h1);
        check("halt.rom_addr", 64'(rom_addr),   64'h15);
        check("halt.valid",    64'(ifid_valid), 64'h0);
        check_counters("halt", 8, 1, 1, 2);

        // requests must be ignored while halted
        halt_req = 1'b0; stall = 1'b1; redirect_pc = 32'h200;
        repeat (5) step();
        check("hold.halted",   64'(halted),   64'h1);
        check("hold.rom_addr", 64'(rom_addr), 64'h15);
        check_counters("hold", 8, 1, 1, 2);

        stall = 1'b0; redirect = 1'b0; go = 1'b1;
        step();
        go = 1'b0;
        check("go.halted", 64'(halted),       64'h0);
        check("go.total",  64'(total_cycles), 64'd8);
        step();
        check("resume.instr", 64'(ifid_instr),   64'hA000_0015);
        check("resume.pc4",   64'(ifid_pc4),     64'h58);
        check("resume.valid", 64'(ifid_valid),   64'h1);
        check("resume.total", 64'(total_cycles), 64'd9);

        rst2 = 1'b0;
        check("wrap.rom_addr0", 64'(rom_addr2), 64'h3FF);
        step();
        check("wrap.rom_addr1", 64'(rom_addr2),   64'h0);
        check("wrap.pc4",       64'(ifid_pc4_2),  64'h0);
        check("wrap.instr",     64'(ifid_instr2), 64'hA000_03FF);
        repeat (14) step();
        check("wrap.cnt_max",   64'(total2), 64'hF);
        step();
        check("wrap.cnt_zero",  64'(total2), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
